// File: rtl/acc_defs_pkg.sv
// rtl/acc_defs_pkg.sv - shared state encoding and width derivations for the batch accelerator wrapper
package acc_defs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ENG = 3'd2,
        ST_WRITE    = 3'd3,
        ST_SUM_WR   = 3'd4,
        ST_DONE     = 3'd5
    } acc_state_e;

    function automatic int smp_w_f(input int u_w, input int v_w);
        return u_w + v_w;
    endfunction

    function automatic int idx_w_f(input int n_samples);
        return (n_samples <= 1) ? 1 : $clog2(n_samples);
    endfunction

endpackage

// File: rtl/acc_sample_shreg.sv
// rtl/acc_sample_shreg.sv - batch sample shift register: parallel load, shift right by one sample, low-slice out
module acc_sample_shreg #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_i,
    input  logic [N*W-1:0] load_data_i,
    input  logic           shift_i,
    output logic [W-1:0]   low_o
);

    logic [N*W-1:0] sh_q;
    logic [N*W-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = load_data_i;
        end else if (shift_i) begin
            sh_d = sh_q >> W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign low_o = sh_q[W-1:0];

endmodule

// File: rtl/accel_batch_wrapper.sv
// rtl/accel_batch_wrapper.sv - batch wrapper feeding samples to an external engine and writing back results
// Optional saturating result sum written after the batch: macro ACC_BATCH_SUM_EN.
module accel_batch_wrapper
    import acc_defs_pkg::*;
#(
    parameter  int U_W       = 2,
    parameter  int V_W       = 6,
    parameter  int N_SAMPLES = 4,
    parameter  int RES_W     = 21,
    localparam int SMP_W     = smp_w_f(U_W, V_W),
    localparam int IDX_W     = idx_w_f(N_SAMPLES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_SAMPLES*SMP_W-1:0] in_data,
    output logic                       busy,
    output logic                       eng_start,
    output logic [SMP_W-1:0]           eng_x,
    input  logic                       eng_done,
    input  logic [RES_W-1:0]           eng_res,
    output logic                       wr_req,
    input  logic                       wr_ack,
    output logic [RES_W-1:0]           wr_data,
    output logic [IDX_W-1:0]           wr_idx,
    output logic                       done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    acc_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              sh_load;
    logic              sh_shift;
    logic [SMP_W-1:0]  sh_low;

    acc_sample_shreg #(
        .W (SMP_W),
        .N (N_SAMPLES)
    ) u_shreg (
        .clk         (clk),
        .rst_n       (rst),
        .load_i      (sh_load),
        .load_data_i (in_data),
        .shift_i     (sh_shift),
        .low_o       (sh_low)
    );

`ifdef ACC_BATCH_SUM_EN
    logic [RES_W-1:0] sum_q, sum_d;
    logic [RES_W:0]   sum_ext;
    logic [RES_W-1:0] sum_sat;

    assign sum_ext = {1'b0, sum_q} + {1'b0, eng_res};
    assign sum_sat = sum_ext[RES_W] ? '1 : sum_ext[RES_W-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        res_d     = res_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        busy      = 1'b1;
        eng_start = 1'b0;
        eng_x     = '0;
        wr_req    = 1'b0;
        wr_data   = '0;
        wr_idx    = '0;
        done      = 1'b0;
`ifdef ACC_BATCH_SUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    sh_load = 1'b1;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
`ifdef ACC_BATCH_SUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_ISSUE: begin
                eng_start = 1'b1;
                eng_x     = sh_low;
                state_d   = ST_WAIT_ENG;
            end
            ST_WAIT_ENG: begin
                eng_x = sh_low;
                if (eng_done) begin
                    res_d   = eng_res;
                    state_d = ST_WRITE;
`ifdef ACC_BATCH_SUM_EN
                    sum_d   = sum_sat;
`endif
                end
            end
            ST_WRITE: begin
                wr_req  = 1'b1;
                wr_data = res_q;
                wr_idx  = idx_q;
                if (wr_ack) begin
                    if (idx_q == LAST_IDX) begin
`ifdef ACC_BATCH_SUM_EN
                        state_d = ST_SUM_WR;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        sh_shift = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end
`ifdef ACC_BATCH_SUM_EN
            ST_SUM_WR: begin
                wr_req  = 1'b1;
                wr_data = sum_q;
                wr_idx  = '1;
                if (wr_ack) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            res_q   <= '0;
`ifdef ACC_BATCH_SUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
`ifdef ACC_BATCH_SUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_accel_batch_wrapper.sv
// tb/tb_accel_batch_wrapper.sv - self-checking bench for accel_batch_wrapper with engine and write-port models
module tb_accel_batch_wrapper;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int RW = 21;
    localparam int IW = 2;
    localparam logic [RW-1:0] JUNK = 21'h1ABCDE;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [N*SW-1:0] in_data = '0;
    logic            busy, eng_start, eng_done, wr_req, done;
    logic            wr_ack = 1'b0;
    logic [SW-1:0]   eng_x;
    logic [RW-1:0]   eng_res, wr_data;
    logic [IW-1:0]   wr_idx;
    logic            eng_done_m = 1'b0;
    logic            spur = 1'b0;
    logic [RW-1:0]   eng_res_m = JUNK;

    assign eng_done = eng_done_m | spur;
    assign eng_res  = eng_res_m;

    always #5 clk = ~clk;

    accel_batch_wrapper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_done  (eng_done),
        .eng_res   (eng_res),
        .wr_req    (wr_req),
        .wr_ack    (wr_ack),
        .wr_data   (wr_data),
        .wr_idx    (wr_idx),
        .done      (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected sample writes of the current batch, in order.
    bit              active = 0, done_due = 0;
    int              issue_cnt = 0, wr_cnt = 0, total_wr = N, done_cnt = 0;
    logic [RW-1:0]   exp_data [0:N];
    logic [IW-1:0]   exp_idx  [0:N];
    logic [N*SW-1:0] exp_in = '0;
    int              res_mode = 0;
    logic [RW-1:0]   salt = '0;
    int              eng_cd = 0;
    bit              eng_wait = 0;
    logic [SW-1:0]   cur_x = '0;
    int              ack_mode = 0, low_idx = -1, low_n = 0, low_cnt = 0;
    bit              hold_v = 0;
    logic [RW-1:0]   hold_d = '0;
    logic [IW-1:0]   hold_i = '0;
    logic [SW-1:0]   x_log [$];
    logic [RW-1:0]   d_log [$];
    logic [IW-1:0]   i_log [$];
    int              cyc = 0, t_start = 0, t_first_issue = -1, t_first_wr = -1, t_done = -1;

    function automatic logic [RW-1:0] eng_fn(input logic [SW-1:0] x);
        case (res_mode)
            0:       return {13'b0, x};
            1:       return RW'({13'b0, x} * 21'd37) + salt;
            default: return 21'h100000;
        endcase
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            hold_v     = 0;
            eng_cd     = 0;
            eng_wait   = 0;
            eng_done_m = 1'b0;
            eng_res_m  = JUNK;
        end else begin
            wr_ack = (ack_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr_req && int'(wr_idx) == low_idx && low_cnt < low_n) begin
                wr_ack = 1'b0;
                low_cnt++;
            end
            if (done) done_cnt++;
            if (!active) begin
                check("idle_quiet", {busy, eng_start, wr_req, done}, 4'b0);
            end else begin
                check("done", done, done_due);
                check("busy", busy, !done_due);
                if (done_due) begin
                    check("done_quiet", {eng_start, wr_req}, 2'b0);
                    active   = 0;
                    done_due = 0;
                    t_done   = cyc - t_start;
                end else begin
                    if (hold_v) begin
                        check("hold_req", wr_req, 1'b1);
                        check("hold_data", wr_data, hold_d);
                        check("hold_idx", wr_idx, hold_i);
                    end
                    hold_v = 0;
                    if (eng_wait) check("eng_x_hold", eng_x, cur_x);
                    if (wr_req) begin
                        if (t_first_wr < 0) t_first_wr = cyc - t_start;
                        if (wr_ack) begin
                            if (wr_cnt < total_wr) begin
                                check("wr_idx", wr_idx, exp_idx[wr_cnt]);
                                check("wr_data", wr_data, exp_data[wr_cnt]);
                            end else begin
                                check("extra_write", 1'b1, 1'b0);
                            end
                            d_log.push_back(wr_data);
                            i_log.push_back(wr_idx);
                            wr_cnt++;
                            if (wr_cnt == total_wr) done_due = 1;
                        end else begin
                            hold_v = 1;
                            hold_d = wr_data;
                            hold_i = wr_idx;
                        end
                    end
                end
            end
            eng_done_m = 1'b0;
            eng_res_m  = JUNK;
            if (eng_cd > 0) begin
                eng_cd--;
                if (eng_cd == 0) begin
                    eng_done_m = 1'b1;
                    eng_res_m  = eng_fn(cur_x);
                    eng_wait   = 0;
                end
            end
            if (active && eng_start) begin
                if (t_first_issue < 0) t_first_issue = cyc - t_start;
                check("issue_order", issue_cnt, wr_cnt);
                check("eng_x", eng_x, (exp_in >> (issue_cnt * SW)) & 32'hFF);
                x_log.push_back(eng_x);
                issue_cnt++;
                cur_x    = eng_x;
                eng_wait = 1;
                eng_cd   = 2;
            end
        end
    end

    task automatic start_batch(input logic [N*SW-1:0] d);
        logic [RW:0] s;
        s = '0;
        @(negedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            exp_data[k] = eng_fn(SW'(d >> (k * SW)));
            exp_idx[k]  = IW'(k);
            s = s + {1'b0, exp_data[k]};
            if (s[RW]) s = {1'b0, {RW{1'b1}}};
        end
`ifdef ACC_BATCH_SUM_EN
        exp_data[N] = s[RW-1:0];
        exp_idx[N]  = '1;
        total_wr    = N + 1;
`else
        total_wr    = N;
`endif
        x_log.delete();
        d_log.delete();
        i_log.delete();
        exp_in        = d;
        in_data       = d;
        issue_cnt     = 0;
        wr_cnt        = 0;
        done_due      = 0;
        t_start       = cyc;
        t_first_issue = -1;
        t_first_wr    = -1;
        t_done        = -1;
        active        = 1;
        start         = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (active && k < 400) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (active) begin
            n_cmp++;
            n_bad++;
            $display("FAIL batch_timeout: got busy expected done within 400 cycles");
            active = 0;
        end
    endtask

    task automatic wait_issue(input int n);
        int k = 0;
        while (issue_cnt < n && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("wait_issue", issue_cnt >= n, 1'b1);
    endtask

    int dc_before;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {busy, eng_start, eng_x, wr_req, wr_data, wr_idx, done}, '0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Directed batch with literal expectations that pin the model.
        start_batch(32'h44332211);
        wait_idle();
        check("lit_x0", x_log[0], 8'h11);
        check("lit_x3", x_log[3], 8'h44);
        check("lit_d1", d_log[1], 21'h22);
        check("lit_d3", d_log[3], 21'h44);
        check("lit_i2", i_log[2], 2'd2);
        check("lit_nwr", d_log.size(), N);
        check("lat_issue", t_first_issue, 1);
        check("lat_wr", t_first_wr, 4);
        check("lat_done", t_done, 17);
        check("done_cnt", done_cnt, 1);

        // Backpressure at idx 1.
        low_idx = 1; low_n = 5; low_cnt = 0;
        start_batch(32'h44332211);
        wait_idle();
        check("bp_cycles", low_cnt, 5);
        check("bp_lat_done", t_done, 22);
        check("bp_d1", d_log[1], 21'h22);
        low_idx = -1;

        // Start during WAIT_ENG with different data is ignored.
        start_batch(32'h8877_6655);
        wait_issue(2);
        @(negedge clk);
        #1 start = 1'b1; in_data = 32'hDEAD_BEEF;
        @(negedge clk);
        #1 start = 1'b0;
        wait_idle();
        check("ign_d2", d_log[2], 21'h77);

        // Reset in WAIT_ENG of sample 2, then a clean batch.
        start_batch(32'hCAFE_F00D);
        wait_issue(3);
        dc_before = done_cnt;
        @(negedge clk);
        #1 rst = 1'b0; active = 0;
        #1 check("rst_mid_outputs", {busy, eng_start, eng_x, wr_req, wr_data, wr_idx, done}, '0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_done", done_cnt, dc_before);
        start_batch(32'h0403_0201);
        wait_idle();
        check("rst_restart_i0", i_log[0], 2'd0);
        check("rst_restart_nwr", d_log.size(), N);

        // Spurious eng_done in IDLE and in WRITE.
        @(negedge clk);
        #1 spur = 1'b1;
        @(negedge clk);
        #1 spur = 1'b0;
        repeat (3) @(negedge clk);
        low_idx = 2; low_n = 6; low_cnt = 0;
        start_batch(32'h1357_9BDF);
        for (int k = 0; k < 200 && low_cnt < 2; k++) begin
            @(negedge clk);
            #2;
        end
        spur = 1'b1;
        @(negedge clk);
        #1 spur = 1'b0;
        wait_idle();
        check("spur_nwr", d_log.size(), N);
        low_idx = -1;

        // Randomised batches with random results and random write backpressure.
        res_mode = 1;
        ack_mode = 1;
        for (int b = 0; b < 20; b++) begin
            salt = RW'($urandom);
            start_batch($urandom);
            wait_idle();
        end
        ack_mode = 0;

`ifdef ACC_BATCH_SUM_EN
        res_mode = 2;
        start_batch(32'h44332211);
        wait_idle();
        check("sum_nwr", d_log.size(), N + 1);
        check("sum_data", d_log[N], 21'h1FFFFF);
        check("sum_idx", i_log[N], 2'b11);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
